serializer_tx: RTL and testbench

- Parallel-to-serial transmitter; the transmit-side counterpart of the existing deserializer.
- Accepts words from the queue/host side through a valid/ready handshake. Holds one word in a pending register while the previous word shifts out.
- Drives one bit per accepted serial beat on data_out, qualified by write_out and throttled by ack_in from the downstream receiver.

---
 rtl/serializer_pkg.sv | 18 +
 rtl/serializer_tx_piso_shift.sv | 28 ++
 rtl/serializer_tx.sv | 155 +++++++++++++++
 tb/tb_serializer_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the serial transmit/receive pair.
package serializer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } tx_state_t;

endpackage

// File: rtl/serializer_tx_piso_shift.sv
// Parallel-in serial-out shift register; the current bit is always the exported end.
module piso_shift #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_word,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_shreg;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_word;
        end else if (i_shift) begin
            r_shreg <= MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
        end
    end

    assign o_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

endmodule

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter with a one-word pending buffer, ack throttling
// and optional idle gap between words.
module serializer_tx
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            word_in,
    input  logic                        word_valid_in,
    output logic                        word_ready_out,
    input  logic                        ack_in,
    output logic                        data_out,
    output logic                        write_out,
    output logic                        status_out,
    output logic [cnt_width(WIDTH)-1:0] bit_cnt_out
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_t        r_state, w_state_d;
    logic [WIDTH-1:0] r_pend, w_pend_d;
    logic             r_pend_full, w_pend_full_d;
    logic             r_write, w_write_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [GAP_W-1:0] r_gap, w_gap_d;
    logic             r_status, w_status_d;

    logic w_accept;
    logic w_beat;
    logic w_load;
    logic w_shift;
    logic w_bit;

    assign w_accept = word_valid_in && !r_pend_full;
    assign w_beat   = r_write && ack_in;

    always_comb begin
        w_state_d     = r_state;
        w_write_d     = r_write;
        w_cnt_d       = r_cnt;
        w_gap_d       = r_gap;
        w_load        = 1'b0;
        w_shift       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (r_pend_full) begin
                    w_load    = 1'b1;
                    w_write_d = 1'b1;
                    w_cnt_d   = CNT_FULL;
                    w_state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (w_beat) begin
                    if (r_cnt > CNT_W'(1)) begin
                        w_shift = 1'b1;
                        w_cnt_d = r_cnt - CNT_W'(1);
                    end else if (GAP_CYCLES > 0) begin
                        w_write_d = 1'b0;
                        w_cnt_d   = '0;
                        w_gap_d   = '0;
                        w_state_d = GAP;
                    end else if (r_pend_full) begin
                        // Reload on the last beat so consecutive words abut.
                        w_load  = 1'b1;
                        w_cnt_d = CNT_FULL;
                    end else begin
                        w_write_d = 1'b0;
                        w_cnt_d   = '0;
                        w_state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (r_gap == GAP_LAST) begin
                    if (r_pend_full) begin
                        w_load    = 1'b1;
                        w_write_d = 1'b1;
                        w_cnt_d   = CNT_FULL;
                        w_state_d = SHIFT;
                    end else begin
                        w_state_d = IDLE;
                    end
                end else begin
                    w_gap_d = r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Load needs a full pending register and accept needs an empty one, so
    // the two never touch pending in the same edge.
    always_comb begin
        w_pend_d      = r_pend;
        w_pend_full_d = r_pend_full;
        if (w_load) begin
            w_pend_full_d = 1'b0;
        end
        if (w_accept) begin
            w_pend_d      = word_in;
            w_pend_full_d = 1'b1;
        end
        w_status_d = (w_state_d != IDLE) || w_pend_full_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_write     <= 1'b0;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_status    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_pend      <= w_pend_d;
            r_pend_full <= w_pend_full_d;
            r_write     <= w_write_d;
            r_cnt       <= w_cnt_d;
            r_gap       <= w_gap_d;
            r_status    <= w_status_d;
        end
    end

    piso_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .i_clock (clock),
        .i_reset (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_word  (r_pend),
        .o_bit   (w_bit)
    );

    assign word_ready_out = !r_pend_full;
    assign data_out       = w_bit;
    assign write_out      = r_write;
    assign status_out     = r_status;
    assign bit_cnt_out    = r_cnt;

endmodule

// File: tb/tb_serializer_tx.sv
// Scoreboard bench: two transmitter configurations, expected bits queued at acceptance.
module tb_serializer_tx;

    typedef struct {
        logic b;
        int   cnt;
        int   gap;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic [7:0] word0 = '0, word1 = '0;
    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic       ack0 = 1'b1, ack1 = 1'b1;
    logic       ready0, ready1, data0, data1, write0, write1, status0, status1;
    logic [3:0] cnt0, cnt1;

    exp_t q0[$];
    exp_t q1[$];
    int   zc0 = 0, zc1 = 0;
    int   tests = 0, fails = 0;

    always #5 clock = ~clock;

    serializer_tx #(
        .WIDTH      (8),
        .MSB_FIRST  (1'b1),
        .GAP_CYCLES (0)
    ) u_dut0 (
        .clock          (clock),
        .reset          (reset),
        .word_in        (word0),
        .word_valid_in  (valid0),
        .word_ready_out (ready0),
        .ack_in         (ack0),
        .data_out       (data0),
        .write_out      (write0),
        .status_out     (status0),
        .bit_cnt_out    (cnt0)
    );

    serializer_tx #(
        .WIDTH      (8),
        .MSB_FIRST  (1'b0),
        .GAP_CYCLES (2)
    ) u_dut1 (
        .clock          (clock),
        .reset          (reset),
        .word_in        (word1),
        .word_valid_in  (valid1),
        .word_ready_out (ready1),
        .ack_in         (ack1),
        .data_out       (data1),
        .write_out      (write1),
        .status_out     (status1),
        .bit_cnt_out    (cnt1)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: a bit is consumed on the coming edge when write && ack.
    always @(negedge clock) begin
        if (reset) begin
            zc0 = 0;
        end else if (!write0) begin
            zc0++;
        end else begin
            if (ack0) begin
                if (q0.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL d0_unexpected_bit: got data %0d required none", data0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("d0_bit", int'(data0), int'(e.b));
                    check("d0_cnt", int'(cnt0), e.cnt);
                    if (e.gap >= 0) check("d0_gap", zc0, e.gap);
                end
            end
            zc0 = 0;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            zc1 = 0;
        end else if (!write1) begin
            zc1++;
        end else begin
            if (ack1) begin
                if (q1.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL d1_unexpected_bit: got data %0d required none", data1);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("d1_bit", int'(data1), int'(e.b));
                    check("d1_cnt", int'(cnt1), e.cnt);
                    if (e.gap >= 0) check("d1_gap", zc1, e.gap);
                end
            end
            zc1 = 0;
        end
    end

    // Offer a word and wait for acceptance; expected bits go to the scoreboard.
    task automatic offer(input int d, input logic [7:0] w, input int gap);
        @(negedge clock);
        if (d == 0) begin word0 = w; valid0 = 1'b1; end
        else        begin word1 = w; valid1 = 1'b1; end
        for (int i = 0; i < 200; i++) begin
            if ((d == 0) ? ready0 : ready1) begin
                for (int j = 0; j < 8; j++) begin
                    exp_t e;
                    e.b   = (d == 0) ? w[7-j] : w[j];
                    e.cnt = 8 - j;
                    e.gap = (j == 0) ? gap : 0;
                    if (d == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
                @(posedge clock);
                #1;
                valid0 = 1'b0;
                valid1 = 1'b0;
                return;
            end
            @(negedge clock);
        end
        check("accept_timeout", 0, 1);
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 300; i++) begin
            @(posedge clock);
            if (((d == 0) ? q0.size() : q1.size()) == 0) break;
        end
        check("drain_empty", (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_d0", {27'd0, ready0, status0, write0, data0, |cnt0}, 32'b10000);
            check("idle_d1", {27'd0, ready1, status1, write1, data1, |cnt1}, 32'b10000);
        end

        // Single word, latency and end-of-word
        offer(0, 8'h52, -1);
        @(negedge clock);
        check("lat_write_k", int'(write0), 0);
        check("lat_ready_k", int'(ready0), 0);
        check("lat_status_k", int'(status0), 1);
        @(negedge clock);
        check("lat_write_k1", int'(write0), 1);
        check("lat_cnt_k1", int'(cnt0), 8);
        drain(0);
        @(negedge clock);
        check("end_write", int'(write0), 0);
        check("end_cnt", int'(cnt0), 0);
        check("end_status", int'(status0), 0);

        // Back-to-back, no bubble on the second word
        offer(0, 8'h52, -1);
        @(negedge clock);
        check("b2b_ready_drop", int'(ready0), 0);
        offer(0, 8'hA5, 0);
        drain(0);
        @(negedge clock);
        check("b2b_end_write", int'(write0), 0);

        // Backpressure at bit 4 (bit index 3 of 8'h52 is 0)
        offer(0, 8'h52, -1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            if (write0 && cnt0 == 4'd4) break;
        end
        ack0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_write", int'(write0), 1);
            check("bp_cnt", int'(cnt0), 4);
            check("bp_data", int'(data0), 0);
        end
        @(posedge clock);
        #1 ack0 = 1'b1;
        drain(0);

        // LSB-first with a 2-cycle gap
        offer(1, 8'h01, -1);
        offer(1, 8'h80, 2);
        drain(1);
        @(negedge clock);
        check("gap_end_write", int'(write1), 0);

        // Async reset mid-word with a pending word
        offer(0, 8'hC3, -1);
        offer(0, 8'h99, 0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            if (write0 && cnt0 == 4'd5) break;
        end
        check("rst_pre_cnt", int'(cnt0), 5);
        check("rst_pre_ready", int'(ready0), 0);
        #1 reset = 1'b1;
        #1;
        check("rst_async", {27'd0, ready0, status0, write0, data0, |cnt0}, 32'b10000);
        q0.delete();
        q1.delete();
        #1 reset = 1'b0;
        offer(0, 8'h3C, -1);
        drain(0);
        repeat (12) @(negedge clock);
        check("rst_no_remnant", int'(write0), 0);
        check("rst_status", int'(status0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
